// File: rtl/gate_truth_table_sequencer.sv
// Steps a 3-input gate through all eight input vectors, samples its output after a settle
// delay and compares the collected truth table against EXPECTED.
module gate_truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'b0111_1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  output logic       gate_c,
  input  logic       gate_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result_vector,
  output logic [7:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  // Counter runs from SETTLE_CYCLES-1 down to 0, so SETTLE lasts SETTLE_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] res_final;

  always_comb begin
    state_nxt      = state;
    res_final      = result_vector;
    res_final[idx] = gate_d;
    case (state)
      IDLE, DONE: if (start) state_nxt = SETTLE;
      SETTLE:     if (cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (idx == 3'd7) ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= 3'd0;
      cnt           <= 4'd0;
      result_vector <= 8'h00;
      fail_mask     <= 8'h00;
      pass          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx           <= 3'd0;
            cnt           <= CNT_LOAD;
            result_vector <= 8'h00;
            fail_mask     <= 8'h00;
            pass          <= 1'b0;
          end
        end
        SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        SAMPLE: begin
          result_vector <= res_final;
          if (idx == 3'd7) begin
            pass      <= (res_final == EXPECTED);
            fail_mask <= res_final ^ EXPECTED;
          end else begin
            idx <= idx + 3'd1;
            cnt <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Status and gate drive decode straight from state so reset clears them immediately.
  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign {gate_a, gate_b, gate_c} = busy ? idx : 3'b000;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench for gate_truth_table_sequencer with a behavioural gate whose function is selectable.
module tb_gate_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       gate_a, gate_b, gate_c, gate_d;
  logic       busy, done, pass;
  logic [7:0] result_vector, fail_mask;
  int         mode = 0;   // 0: NAND3, 1: AND3, 2: stuck-at-1
  int         n_chk = 0;
  int         n_fail = 0;

  gate_truth_table_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(8'h7F)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gate_a(gate_a), .gate_b(gate_b), .gate_c(gate_c), .gate_d(gate_d),
    .busy(busy), .done(done), .pass(pass),
    .result_vector(result_vector), .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       gate_d = gate_a & gate_b & gate_c;
      2:       gate_d = 1'b1;
      default: gate_d = ~(gate_a & gate_b & gate_c);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Covers one run whose start edge is the next posedge: the gate vector sequence,
  // pass/fail_mask held at 0 while busy, then the final results one edge after vector 7.
  task automatic check_run(input logic [7:0] rv, input bit hold, input bit pulses);
    logic [2:0] v;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) start = 1'b0;
      v = 3'(k / 3);
      chk($sformatf("run_k%0d", k), {busy, done, pass, gate_a, gate_b, gate_c, fail_mask},
          {1'b1, 1'b0, 1'b0, v, 8'h00});
      if (pulses) begin
        if (k == 5 || k == 12) start = 1'b1;
        if (k == 6 || k == 13) start = 1'b0;
      end
    end
    @(negedge clk);
    chk("end_flags", {busy, done, gate_a, gate_b, gate_c}, {1'b0, 1'b1, 3'b000});
    chk("end_result", result_vector, rv);
    chk("end_mask", fail_mask, rv ^ 8'h7F);
    chk("end_pass", pass, (rv == 8'h7F));
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {busy, done, pass, gate_a, gate_b, gate_c, result_vector, fail_mask}, 22'd0);
  endtask

  initial begin
    // Reset held with clock toggling
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("idle_after_reset");

    // Correct NAND
    mode = 0;
    @(negedge clk); start = 1'b1;
    check_run(8'h7F, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_holds", {done, pass, result_vector}, {1'b1, 1'b1, 8'h7F});

    // AND gate in place of NAND
    mode = 1;
    @(negedge clk); start = 1'b1;
    check_run(8'h80, 1'b0, 1'b0);

    // Stuck-at-1, then a second start repeats the run
    mode = 2;
    @(negedge clk); start = 1'b1;
    check_run(8'hFF, 1'b0, 1'b0);
    @(negedge clk); start = 1'b1;
    check_run(8'hFF, 1'b0, 1'b0);

    // start pulses during a run are ignored
    mode = 0;
    @(negedge clk); start = 1'b1;
    check_run(8'h7F, 1'b0, 1'b1);

    // start held high: back-to-back runs with a single done cycle between
    @(negedge clk); start = 1'b1;
    check_run(8'h7F, 1'b1, 1'b0);
    check_run(8'h7F, 1'b0, 1'b0);

    // Reset mid-run while vector 4 is applied
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    chk("pre_reset_vec", {busy, gate_a, gate_b, gate_c}, {1'b1, 3'b100});
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("idle_after_midrun_reset");
    @(negedge clk); start = 1'b1;
    check_run(8'h7F, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_sequencer.md
Name: gate_truth_table_sequencer

Overview:
- Controller that exercises a 3-input combinational gate under test (default: the team's 3-input NAND) through all 8 input combinations in ascending order.
- Waits a programmable settle time per vector, samples the gate output and builds an 8-bit observed truth table.
- Compares the table against an expected table and reports pass/fail plus a per-vector mismatch mask.
- Sits between the lab's start button/debounce logic and the gate instance on the FPGA board.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before its sample cycle; legal range 1..15; 0 is illegal.
- EXPECTED, 8'b0111_1111, expected gate output indexed by vector {a,b,c}. Default is the 3-input NAND.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  run request, sampled on the rising edge of clk
- gate_a  output  1  gate input a (MSB of vector index)
- gate_b  output  1  gate input b
- gate_c  output  1  gate input c (LSB of vector index)
- gate_d  input  1  gate output under test
- busy  output  1  high while a run is in progress
- done  output  1  high while results of a completed run are valid
- pass  output  1  1 when result_vector == EXPECTED; valid while done=1
- result_vector  output  8  bit i = gate_d sampled for vector i
- fail_mask  output  8  result_vector ^ EXPECTED; valid while done=1

Behaviour:
- Clocking/reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Asserting rst_n=0 takes effect immediately, regardless of clk.
- Reset values:
  - state=IDLE; idx=0; settle counter=0
  - gate_a/b/c=0, busy=0, done=0, pass=0
  - result_vector=8'h00, fail_mask=8'h00
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 at an edge:
  - clear result_vector, fail_mask, pass and done; idx=0
  - drive {gate_a,gate_b,gate_c}=3'b000; load the counter; go to SETTLE
  - busy=1 from that edge.
- SETTLE: held exactly SETTLE_CYCLES cycles, counter decrementing; then go to SAMPLE.
- SAMPLE: lasts one cycle. At its closing edge:
  - result_vector[idx] <= gate_d
  - if idx==7, go to DONE
  - else idx <= idx+1, drive the new vector on gate_a/b/c at the same edge, reload the counter, go to SETTLE.
- Vector mapping: {gate_a,gate_b,gate_c} = idx[2:0]. Inputs are stable for the whole SETTLE+SAMPLE window.
- Latency: each vector occupies SETTLE_CYCLES+1 cycles. done rises 8*(SETTLE_CYCLES+1) edges after the start edge (24 with the default).
- Entering DONE:
  - busy=0, done=1
  - pass = (final result_vector == EXPECTED)
  - fail_mask = final result_vector ^ EXPECTED
  - gate inputs return to 3'b000.
  - done, pass and fail_mask hold until the next start or reset.
- start while busy=1: ignored; no restart and no effect on the run.
- start held high continuously: a new run begins on the edge after DONE is entered, so done is high for exactly one cycle between runs.
- result_vector updates bit by bit during a run and may be read while busy. pass and fail_mask read 0 until done=1.
- Reset mid-run: all outputs return to their reset values asynchronously. Partial results are discarded, and a new start is required.

Test Plan:
- Reset: hold rst_n=0 and toggle clk -> all outputs 0, gate inputs 3'b000; release -> remains IDLE with no activity.
- Correct NAND, SETTLE_CYCLES=2, 1-cycle start pulse -> gate inputs step 000..111 every 3 cycles, busy high for 24 cycles, then done=1, pass=1, result_vector=8'h7F, fail_mask=8'h00.
- gate_d driven by a 3-input AND -> result_vector=8'h80, fail_mask=8'hFF, pass=0.
- gate_d stuck at 1 -> result_vector=8'hFF, fail_mask=8'h80, pass=0. Then a second start -> done drops the cycle after start and the run repeats.
- start pulsed at cycles 5 and 12 of a run -> no restart, done still 24 cycles after the first start. With start held high -> done high exactly 1 cycle between back-to-back runs.
- rst_n pulsed low during vector idx=4 -> busy, done, result_vector and gate inputs go to 0 immediately. A fresh start completes normally with result_vector=8'h7F.
